// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax2 request scheduler.
//   FP_W          : width of an FP32 operand/result word
//   sched_state_e : scheduler FSM states
//   clog2()       : ceiling log2, usable in constant expressions
package softmax_pkg;

   localparam int unsigned FP_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } sched_state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : per-requester request bits
//   ptr_i : index where the search starts (highest priority)
//   gnt_o : one-hot grant, zero when no request
//   idx_o : index of the granted requester
//   any_o : at least one request present
module rr_arbiter
   import softmax_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [ID_W-1:0]    idx_o,
   output logic               any_o
);

   int unsigned cand;

   // Walk from ptr_i upward; the wrap is explicit so non power-of-2 counts work.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = 32'(ptr_i) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!any_o && req_i[cand[ID_W-1:0]]) begin
            any_o                  = 1'b1;
            gnt_o[cand[ID_W-1:0]]  = 1'b1;
            idx_o                  = cand[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/softmax2_sched.sv
// Round-robin scheduler sharing one 2-class softmax unit among NUM_REQ heads.
// One transaction in flight: IDLE (grant) -> ISSUE (launch) -> WAIT -> RESP.
//   clk, reset          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester request, one-hot single-cycle grant
//   req_class0/1        : packed FP32 logit pairs, requester i at [32i+31:32i]
//   sm_*                : launch strobe/operands to, results/done from the softmax unit
//   rsp_*               : tagged response, held until rsp_ready
//   stray_err           : sticky, completion strobe seen outside WAIT
//   busy                : FSM not idle
module softmax2_sched
   import softmax_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [FP_W*NUM_REQ-1:0] req_class0,
   input  logic [FP_W*NUM_REQ-1:0] req_class1,
   output logic                    sm_valid_in,
   output logic [FP_W-1:0]         sm_class0,
   output logic [FP_W-1:0]         sm_class1,
   input  logic [FP_W-1:0]         sm_out0,
   input  logic [FP_W-1:0]         sm_out1,
   input  logic                    sm_valid_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [FP_W-1:0]         rsp_out0,
   output logic [FP_W-1:0]         rsp_out1,
   output logic                    rsp_timeout,
   output logic                    stray_err,
   output logic                    busy
);

   localparam int unsigned WdogW = clog2(TIMEOUT);

   sched_state_e     state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic [FP_W-1:0]  sm_class0_q, sm_class0_d;
   logic [FP_W-1:0]  sm_class1_q, sm_class1_d;
   logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
   logic [FP_W-1:0]  rsp_out0_q, rsp_out0_d;
   logic [FP_W-1:0]  rsp_out1_q, rsp_out1_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             stray_q, stray_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [FP_W-1:0]    sel_class0, sel_class1;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // One-hot grant makes an OR-mux sufficient for operand selection.
   always_comb begin
      sel_class0 = '0;
      sel_class1 = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_class0 = sel_class0 | req_class0[i*FP_W +: FP_W];
            sel_class1 = sel_class1 | req_class1[i*FP_W +: FP_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      wdog_d        = wdog_q;
      sm_class0_d   = sm_class0_q;
      sm_class1_d   = sm_class1_q;
      rsp_id_d      = rsp_id_q;
      rsp_out0_d    = rsp_out0_q;
      rsp_out1_d    = rsp_out1_q;
      rsp_timeout_d = rsp_timeout_q;
      stray_d       = stray_q;

      if (sm_valid_out && (state_q != StWait)) stray_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (gnt_any) begin
               sm_class0_d = sel_class0;
               sm_class1_d = sel_class1;
               rsp_id_d    = gnt_idx;
               rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
               state_d     = StIssue;
            end
         end
         StIssue: begin
            wdog_d  = '0;
            state_d = StWait;
         end
         StWait: begin
            wdog_d = wdog_q + WdogW'(1);
            // Completion takes priority over a coincident watchdog expiry.
            if (sm_valid_out) begin
               rsp_out0_d    = sm_out0;
               rsp_out1_d    = sm_out1;
               rsp_timeout_d = 1'b0;
               state_d       = StResp;
            end else if (wdog_q == WdogW'(TIMEOUT - 1)) begin
               rsp_out0_d    = '0;
               rsp_out1_d    = '0;
               rsp_timeout_d = 1'b1;
               state_d       = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= StIdle;
         rr_ptr_q      <= '0;
         wdog_q        <= '0;
         sm_class0_q   <= '0;
         sm_class1_q   <= '0;
         rsp_id_q      <= '0;
         rsp_out0_q    <= '0;
         rsp_out1_q    <= '0;
         rsp_timeout_q <= 1'b0;
         stray_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         wdog_q        <= wdog_d;
         sm_class0_q   <= sm_class0_d;
         sm_class1_q   <= sm_class1_d;
         rsp_id_q      <= rsp_id_d;
         rsp_out0_q    <= rsp_out0_d;
         rsp_out1_q    <= rsp_out1_d;
         rsp_timeout_q <= rsp_timeout_d;
         stray_q       <= stray_d;
      end
   end

   // Grant is combinational; masked while reset is held so nothing is offered then.
   assign req_ready   = ((state_q == StIdle) && reset) ? gnt : '0;
   assign sm_valid_in = (state_q == StIssue);
   assign sm_class0   = sm_class0_q;
   assign sm_class1   = sm_class1_q;
   assign rsp_valid   = (state_q == StResp);
   assign rsp_id      = rsp_id_q;
   assign rsp_out0    = rsp_out0_q;
   assign rsp_out1    = rsp_out1_q;
   assign rsp_timeout = rsp_timeout_q;
   assign stray_err   = stray_q;
   assign busy        = (state_q != StIdle);

endmodule
